// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port ROM arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } state_t;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rom_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker: ptr names the requester favoured on a tie.
module rr_arb2
  import rom_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       valid
);

  always_comb begin
    gnt          = '0;
    gnt[REQ0]    = req[REQ0] & (~req[REQ1] | (ptr == REQ0));
    gnt[REQ1]    = req[REQ1] & (~req[REQ0] | (ptr == REQ1));
    valid        = |req;
  end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin sequencer sharing one async-read ROM between two held-request clients.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_spo
);

  state_t     state;
  logic       owner;
  logic       rr_ptr;
  logic [1:0] arb_req;
  logic [1:0] pick_gnt;
  logic       pick_valid;

  // The current owner is masked in RESP so its re-asserted req waits for IDLE.
  always_comb begin
    arb_req = {req1, req0};
    if (state == RESP) arb_req[owner] = 1'b0;
  end

  rr_arb2 u_pick (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= REQ0;
      rr_ptr   <= REQ0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      rom_addr <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (pick_valid) begin
            state    <= LOOKUP;
            owner    <= pick_gnt[REQ1];
            rom_addr <= pick_gnt[REQ0] ? addr0 : addr1;
            busy     <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LOOKUP: begin
          state  <= RESP;
          rdata  <= rom_spo;
          rr_ptr <= ~owner;
          if (owner == REQ1) ack1 <= 1'b1;
          else               ack0 <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
